// File: rtl/dl_rr_arb_reg.sv
// Round-robin arbiter that feeds one output register. Registered output with 1-cycle latency.
// Backpressure: req_ready is held low while a full register waits on out_ready; a drain and a refill can happen in the same cycle.
module dl_rr_arb_reg #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int SW      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [SW-1:0]            out_src,
    input  logic                     out_ready
);

    logic [SW-1:0]    ptr;
    logic [SW-1:0]    win;
    logic [SW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] win_dat;
    logic             any_vld;
    logic             accept;
    logic             xfer;

    // Index k places after ptr. The wrap is at NUM_REQ, so non-power-of-2 sizes never reach unused indices.
    function automatic logic [SW-1:0] rot(input logic [SW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return SW'(s);
    endfunction

    // Scan from the farthest position back toward ptr, so the nearest valid requester is the one kept.
    always_comb begin
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rot(ptr, k)]) begin
                win = rot(ptr, k);
            end
        end
    end

    assign any_vld = |req_valid;
    assign accept  = ~out_valid | out_ready;
    assign xfer    = accept & any_vld;
    assign win_dat = req_data[int'(win)*WIDTH +: WIDTH];
    assign ptr_nxt = (win == SW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        req_ready = '0;
        if (!rst && xfer) begin
            req_ready = NUM_REQ'(1) << win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_dat;
            out_src   <= win;
            ptr       <= ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dl_rr_arb_reg.sv
// Randomized and directed bench for dl_rr_arb_reg. It drives a 4-requester instance and a 3-requester instance side by side.
module tb_dl_rr_arb_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  rv4;
    logic [2:0]  rv3;
    logic        ordy4, ordy3;
    logic [31:0] dat [2][4];
    logic [127:0] rd4;
    logic [95:0]  rd3;
    logic [3:0]  rr4;
    logic [2:0]  rr3;
    logic        ov4, ov3;
    logic [31:0] od4, od3;
    logic [1:0]  os4, os3;

    always_comb begin
        rd4 = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
        rd3 = {dat[1][2], dat[1][1], dat[1][0]};
    end

    dl_rr_arb_reg #(.NUM_REQ(4), .WIDTH(32)) dut4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_data(rd4), .req_ready(rr4),
        .out_valid(ov4), .out_data(od4), .out_src(os4), .out_ready(ordy4));

    dl_rr_arb_reg #(.NUM_REQ(3), .WIDTH(32)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
        .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(ordy3));

    // Reference state: one buffered word per instance plus its priority pointer.
    bit          m_vld [2];
    logic [31:0] m_dat [2];
    int          m_src [2];
    int          m_ptr [2];
    int          n_pass = 0;
    int          n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int pick(input logic [15:0] v, input int p, input int n);
        int i;
        for (int k = 0; k < n; k++) begin
            i = (p + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_vld[d] = 0; m_dat[d] = '0; m_src[d] = 0; m_ptr[d] = 0;
        end
    endtask

    task automatic cycle();
        logic [15:0] v;
        logic [63:0] erdy;
        int n, w;
        bit acc, ordy;
        bit          nv [2];
        logic [31:0] nd [2];
        int          ns [2];
        int          np [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n    = (d == 1) ? 3 : 4;
            v    = (d == 1) ? 16'(rv3) : 16'(rv4);
            ordy = (d == 1) ? ordy3 : ordy4;
            acc  = !m_vld[d] || ordy;
            w    = pick(v, m_ptr[d], n);
            erdy = (acc && w >= 0) ? (64'd1 << w) : 64'd0;
            chk($sformatf("n%0d req_ready", n), (d == 1) ? 64'(rr3) : 64'(rr4), erdy);
            chk($sformatf("n%0d out_valid", n), (d == 1) ? 64'(ov3) : 64'(ov4), 64'(m_vld[d]));
            chk($sformatf("n%0d out_data", n), (d == 1) ? 64'(od3) : 64'(od4), 64'(m_dat[d]));
            chk($sformatf("n%0d out_src", n), (d == 1) ? 64'(os3) : 64'(os4), 64'(m_src[d]));
            chk($sformatf("n%0d ptr", n), (d == 1) ? 64'(dut3.ptr) : 64'(dut4.ptr), 64'(m_ptr[d]));
            nv[d] = m_vld[d]; nd[d] = m_dat[d]; ns[d] = m_src[d]; np[d] = m_ptr[d];
            if (acc && w >= 0) begin
                nv[d] = 1; nd[d] = dat[d][w]; ns[d] = w; np[d] = (w + 1) % n;
            end else if (m_vld[d] && ordy) begin
                nv[d] = 0;
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_vld[d] = nv[d]; m_dat[d] = nd[d]; m_src[d] = ns[d]; m_ptr[d] = np[d];
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rv4 = '0; rv3 = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data_fixed();
        for (int i = 0; i < 4; i++) begin
            dat[0][i] = 32'h100 + i;
            dat[1][i] = 32'h200 + i;
        end
    endtask

    initial begin
        rst = 1'b0; rv4 = '0; rv3 = '0; ordy4 = 1'b0; ordy3 = 1'b0;
        set_data_fixed();
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("reset out_valid", 64'(ov4), 64'd0);
        chk("reset out_data", 64'(od4), 64'd0);
        chk("reset out_src", 64'(os4), 64'd0);
        rv4 = 4'hf;
        #1;
        chk("reset req_ready", 64'(rr4), 64'd0);
        rv4 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        repeat (3) cycle();

        // All four requesters valid, drain every cycle: strict rotation, no bubbles.
        do_reset();
        set_data_fixed();
        rv4 = 4'hf; rv3 = 3'h7; ordy4 = 1'b1; ordy3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rot4 src", 64'(os4), 64'(k % 4));
            chk("rot4 data", 64'(od4), 64'(32'h100 + k % 4));
            chk("rot3 src", 64'(os3), 64'(k % 3));
        end

        // Lone requester 2, then requester 1 joins after ptr has moved to 3.
        do_reset();
        rv4 = 4'b0100; rv3 = 3'b100;
        repeat (4) cycle();
        chk("lone src", 64'(os4), 64'd2);
        rv4 = 4'b0110;
        cycle();
        chk("wrap grant 1", 64'(os4), 64'd1);
        cycle();
        chk("then grant 2", 64'(os4), 64'd2);

        // Stall with everyone requesting, then release.
        rv4 = 4'hf; rv3 = 3'h7;
        ordy4 = 1'b0; ordy3 = 1'b0;
        repeat (5) cycle();
        ordy4 = 1'b1; ordy3 = 1'b1;
        repeat (4) cycle();

        // One transfer then silence: valid drops after one cycle and ptr stays at 1.
        do_reset();
        rv4 = 4'b0001; rv3 = 3'b001;
        cycle();
        rv4 = '0; rv3 = '0;
        repeat (3) cycle();
        chk("idle ptr", 64'(dut4.ptr), 64'd1);
        chk("idle valid", 64'(ov4), 64'd0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            rv4 = 4'($urandom); rv3 = 3'($urandom);
            ordy4 = ($urandom_range(0, 3) != 0); ordy3 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                dat[0][i] = $urandom; dat[1][i] = $urandom;
            end
            cycle();
        end

        // Asynchronous reset while a word is held: outputs clear before the next edge.
        rv4 = 4'hf; rv3 = 3'h7; ordy4 = 1'b0; ordy3 = 1'b0;
        cycle();
        #2 rst = 1'b1;
        rv4 = '0; rv3 = '0;
        #1;
        chk("async out_valid", 64'(ov4), 64'd0);
        chk("async out_data", 64'(od4), 64'd0);
        chk("async out_src", 64'(os4), 64'd0);
        chk("async req_ready", 64'(rr4), 64'd0);
        chk("async n3 out_valid", 64'(ov3), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rv4 = 4'b1000; rv3 = 3'b010; ordy4 = 1'b1; ordy3 = 1'b1;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dl_rr_arb_reg.md
# dl_rr_arb_reg

Round-robin arbiter that shares one output register between `NUM_REQ` requesters using valid/ready handshakes. Each cycle it grants at most one requester and loads that requester's data and index into a single-entry output register. It sits in front of shared single-port consumers in the core, such as a register write port or a memory request port. The output register is built from the library's flip-flop style storage: one clock, no enable gating.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16, any value (non-power-of-2 allowed).
- `WIDTH`, default 32: payload width in bits.
- `SW`, default `$clog2(NUM_REQ)`: width of the source index; derived, not overridden.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  NUM_REQ  bit i: requester i presents data.
- `req_data`  in  NUM_REQ*WIDTH  requester i payload at bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  bit i: requester i's payload is taken this cycle; one-hot or zero.
- `out_valid`  out  1  output register holds data.
- `out_data`  out  WIDTH  registered payload.
- `out_src`  out  SW  index of the requester that supplied `out_data`.
- `out_ready`  in  1  consumer takes `out_data` this cycle.

## Operation
- Internal state: `ptr` [SW-1:0], the highest-priority requester index; plus the `out_*` registers.
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0. `req_ready` is all-zero while `rst` is asserted.
- Combinational `accept = ~out_valid | out_ready`, meaning the register is empty or draining this cycle.
- Winner: the first i with `req_valid[i]`=1, searching `ptr`, `ptr+1`, … up to `NUM_REQ-1`, then wrapping to 0 and continuing to `ptr-1`. The wrap is modulo `NUM_REQ`, not modulo 2^SW.
- `req_ready[winner] = accept & |req_valid`. All other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Transfer on requester i (`req_valid[i] & req_ready[i]`), at the next edge:
  - `out_data <= req_data[i]`, `out_src <= i`, `out_valid <= 1`.
  - `ptr <= (i == NUM_REQ-1) ? 0 : i+1`.
- Drain with no transfer (`out_valid & out_ready`, no `req_valid`): `out_valid <= 0`. `out_data`, `out_src` and `ptr` hold.
- Stall (`out_valid & ~out_ready`):
  - All `req_ready` bits are 0; all registers hold.
  - `out_data` and `out_src` must stay stable while `out_valid=1` and `out_ready=0`.
- Simultaneous drain and transfer in the same cycle: new data replaces the old and `out_valid` stays 1. No bubble.
- `out_ready` while `out_valid=0` is ignored.
- `ptr` advances only on a transfer, never on idle cycles.
- Async reset mid-operation: outputs return to reset values immediately. Any held, un-drained payload is discarded with no transfer reported.

## Timing
- Latency: requester transfer at edge N gives `out_valid=1` with that data in cycle N+1.
- Throughput: one transfer per cycle when `out_ready` is held at 1.
- Fairness: a requester holding `req_valid` continuously is granted within `NUM_REQ` transfers.
- No combinational path from `req_*` to `out_*`.
- Combinational paths exist from `out_ready` and `req_valid` to `req_ready`.

## Test plan
- Reset, then idle: `out_valid`=0, `out_data`=0, `out_src`=0, `req_ready`=0. Assert `rst` asynchronously mid-transfer → outputs clear before the next edge.
- All 4 requesters valid, `req_data[i]`=0x100+i, `out_ready`=1 for 8 cycles → `out_src` sequence 0,1,2,3,0,1,2,3 with matching data. One `req_ready` bit high per cycle.
- Only requester 2 valid, `out_ready`=1 → a transfer every cycle, `out_src`=2. Then also raise requester 1 → next grant is 1 (ptr=3 wraps), then 2.
- `out_valid`=1 with `out_ready`=0 for 5 cycles, all requesters valid → `req_ready`=0, `out_data`/`out_src` stable. Release `out_ready` → back-to-back transfers resume with no bubble.
- `NUM_REQ`=3, all valid, `out_ready`=1 → `out_src` 0,1,2,0,1,2. `ptr` never takes the value 3.
- Single transfer, then no requests, `out_ready`=1 → `out_valid` falls after one cycle and `ptr` holds at 1.
